// File: rtl/display_pkg.sv
// Shared encodings and constants for the register display scheduler.
package display_pkg;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_COMMIT} state_t;

    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0]  BCD_ADJ        = 4'd3;
    localparam int unsigned SHIFT_STEPS    = 8;

    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        return (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ : digit;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta, sync, sync_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            meta      <= din;
            sync      <= meta;
            sync_prev <= sync;
        end
    end

    assign pulse = sync & ~sync_prev;

endmodule

// File: rtl/reg_display_scheduler.sv
// Rotates the 7-segment display between observed registers and converts the
// selected byte to three BCD digits with a sequential double-dabble.
module reg_display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 5,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [8*NUM_SRC-1:0] src_bus,
    input  logic                 hold,
    input  logic                 adv,
    output logic [3:0]           bcd_hund,
    output logic [3:0]           bcd_tens,
    output logic [3:0]           bcd_units,
    output logic [2:0]           src_idx,
    output logic                 valid
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       PAGE_LAST  = 3'(NUM_SRC - 1);
    localparam logic [2:0]       STEP_LAST  = 3'(SHIFT_STEPS - 1);

    state_t           state, state_nxt;
    logic             adv_pulse, page_step;
    logic [CNT_W-1:0] dwell;
    logic [2:0]       page, samp_idx, bit_cnt;
    logic [7:0]       cur_src, shreg;
    logic [11:0]      scratch, adj;
    logic [19:0]      shifted;

    sync_edge_detect u_adv_sync (
        .clock (clock),
        .reset (reset),
        .din   (adv),
        .pulse (adv_pulse)
    );

    assign page_step = !hold && (dwell == DWELL_LAST);

    // A coincident page_step and adv_pulse still advance the page only once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dwell <= '0;
            page  <= '0;
        end else begin
            if (adv_pulse || page_step) begin
                dwell <= '0;
                page  <= (page == PAGE_LAST) ? 3'd0 : page + 3'd1;
            end else if (!hold) begin
                dwell <= dwell + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cur_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (page == k[2:0]) cur_src = src_bus[8*k +: 8];
        end
    end

    assign adj     = {bcd_adjust(scratch[11:8]), bcd_adjust(scratch[7:4]),
                      bcd_adjust(scratch[3:0])};
    assign shifted = {adj, shreg} << 1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD:   state_nxt = S_SHIFT;
            S_SHIFT:  if (bit_cnt == STEP_LAST) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_LOAD;
            default:  state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            samp_idx  <= '0;
            bcd_hund  <= '0;
            bcd_tens  <= '0;
            bcd_units <= '0;
            src_idx   <= '0;
            valid     <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    shreg    <= cur_src;
                    scratch  <= '0;
                    bit_cnt  <= '0;
                    samp_idx <= page;
                end
                S_SHIFT: begin
                    {scratch, shreg} <= shifted;
                    bit_cnt          <= bit_cnt + 3'd1;
                end
                S_COMMIT: begin
                    bcd_hund  <= scratch[11:8];
                    bcd_tens  <= scratch[7:4];
                    bcd_units <= scratch[3:0];
                    src_idx   <= samp_idx;
                    valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
